// File: rtl/crc32_pkg.sv
// Shared CRC-32 (reflected, poly 0xEDB88320) constants and byte-step helper
// used by both the frame generator and the receive-side checker.
package crc32_pkg;

   localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
   localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FRAME = 1'b1
   } rx_state_t;

   // One entry of the 256-word lookup table; constant-folds to a ROM per index.
   function automatic logic [31:0] crc32_table_entry(input logic [7:0] idx);
      logic [31:0] c;
      c = {24'h0, idx};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
      end
      return c;
   endfunction

   function automatic logic [31:0] crc32_byte_step(input logic [31:0] crc,
                                                   input logic [7:0]  data);
      return (crc >> 8) ^ crc32_table_entry(crc[7:0] ^ data);
   endfunction

endpackage

// File: rtl/crc32_fcs_delay.sv
// Four-byte shift register that holds back the trailing FCS bytes; a push into
// a full line pops the oldest byte. Flush empties it before any same-cycle push.
module crc32_fcs_delay (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       flush,
   input  logic [7:0] data,
   output logic       pop_valid,
   output logic [7:0] pop_data
);

   logic [7:0] line [4];
   logic [2:0] occupancy;

   assign pop_valid = push & ~flush & (occupancy == 3'd4);
   assign pop_data  = line[3];

   always_ff @(posedge clk) begin
      if (rst) begin
         occupancy <= 3'd0;
         for (int i = 0; i < 4; i++) begin
            line[i] <= 8'h00;
         end
      end else begin
         if (push) begin
            line[0] <= data;
            for (int i = 1; i < 4; i++) begin
               line[i] <= line[i-1];
            end
         end
         // With flush and push together the new byte becomes the only entry.
         if (flush) begin
            occupancy <= push ? 3'd1 : 3'd0;
         end else if (push && occupancy != 3'd4) begin
            occupancy <= occupancy + 3'd1;
         end
      end
   end

endmodule

// File: rtl/crc32_rx_checker.sv
// Receive-side CRC-32 checker: verifies the trailing FCS, strips it through a
// 4-byte delay line, and reports one status pulse per terminated frame.
module crc32_rx_checker
   import crc32_pkg::*;
#(
   parameter int LEN_W     = 16,
   parameter int MIN_FRAME = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_sop,
   input  logic             in_eop,
   output logic             out_valid,
   output logic [7:0]       out_data,
   output logic             out_last,
   output logic             stat_valid,
   output logic             stat_crc_ok,
   output logic             stat_runt,
   output logic             stat_abort,
   output logic [LEN_W-1:0] stat_len
);

   localparam logic [LEN_W-1:0] LEN_MAX   = '1;
   localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
   localparam logic [LEN_W-1:0] FCS_LEN   = LEN_W'(4);
   localparam logic [LEN_W-1:0] MIN_TOTAL = LEN_W'(MIN_FRAME);

   rx_state_t        state;
   logic [31:0]      crc_q;
   logic [31:0]      next_crc;
   logic [LEN_W-1:0] count_q;
   logic [LEN_W-1:0] total;
   logic [LEN_W-1:0] fwd_len;
   logic             runt;
   logic             push;
   logic             flush;
   logic             pop_valid;
   logic [7:0]       pop_data;

   // The line is emptied while idle, so an eop leaves no stale FCS behind.
   always_comb begin
      next_crc = crc32_byte_step(in_sop ? CRC32_INIT : crc_q, in_data);
      total    = (count_q == LEN_MAX) ? LEN_MAX : count_q + LEN_ONE;
      runt     = total < MIN_TOTAL;
      fwd_len  = (count_q > FCS_LEN) ? count_q - FCS_LEN : '0;
      push     = in_valid & (in_sop | (state == ST_FRAME));
      flush    = (state == ST_IDLE) | (in_valid & in_sop);
   end

   crc32_fcs_delay u_fcs_delay (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .flush     (flush),
      .data      (in_data),
      .pop_valid (pop_valid),
      .pop_data  (pop_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         crc_q       <= CRC32_INIT;
         count_q     <= '0;
         out_valid   <= 1'b0;
         out_data    <= 8'h00;
         out_last    <= 1'b0;
         stat_valid  <= 1'b0;
         stat_crc_ok <= 1'b0;
         stat_runt   <= 1'b0;
         stat_abort  <= 1'b0;
         stat_len    <= '0;
      end else begin
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         stat_valid <= 1'b0;
         if (in_valid && state == ST_FRAME && !in_sop) begin
            crc_q   <= next_crc;
            count_q <= total;
            if (pop_valid) begin
               out_valid <= 1'b1;
               out_data  <= pop_data;
               out_last  <= in_eop & ~runt;
            end
            if (in_eop) begin
               stat_valid  <= 1'b1;
               stat_crc_ok <= (next_crc == CRC32_RESIDUE) & ~runt;
               stat_runt   <= runt;
               stat_abort  <= 1'b0;
               stat_len    <= runt ? '0 : total - FCS_LEN;
               state       <= ST_IDLE;
            end
         end else if (in_valid && in_sop) begin
            // An abort's status takes the single pulse if the new sop is also eop.
            if (state == ST_FRAME) begin
               stat_valid  <= 1'b1;
               stat_crc_ok <= 1'b0;
               stat_runt   <= 1'b0;
               stat_abort  <= 1'b1;
               stat_len    <= fwd_len;
            end else if (in_eop) begin
               stat_valid  <= 1'b1;
               stat_crc_ok <= 1'b0;
               stat_runt   <= 1'b1;
               stat_abort  <= 1'b0;
               stat_len    <= '0;
            end
            if (in_eop) begin
               state <= ST_IDLE;
            end else begin
               state   <= ST_FRAME;
               crc_q   <= next_crc;
               count_q <= LEN_ONE;
            end
         end
      end
   end

endmodule

// File: doc/crc32_rx_checker.md
Name: crc32_rx_checker

Overview:
Receive-side companion to the byte-wise CRC-32 generator. It consumes a byte stream framed by sop/eop in which the last 4 bytes of each frame are the FCS: the CRC-32 transmitted least-significant byte first.
- Runs the same reflected CRC-32 over every byte, including the FCS.
- Strips the FCS through a 4-byte delay line and forwards payload bytes with an end marker.
- Reports per-frame status one cycle after eop: CRC good/bad, payload length, runt, abort.
- Sits between the byte deserializer and the frame buffer.

Parameters:
LEN_W, 16, width of the payload length counter; the counter saturates at 2^LEN_W-1.
MIN_FRAME, 5, minimum total bytes (FCS included) for a frame to be non-runt; legal range is 5 or greater.

Ports:
clk  in  1  single clock; all logic is on the rising edge.
rst  in  1  reset, synchronous, active-high.
in_valid  in  1  byte qualifier.
in_data  in  8  received byte.
in_sop  in  1  first byte of frame; qualified by in_valid.
in_eop  in  1  last byte of frame; qualified by in_valid. May coincide with in_sop.
out_valid  out  1  payload byte valid.
out_data  out  8  payload byte.
out_last  out  1  last payload byte of the frame.
stat_valid  out  1  one-cycle status pulse per terminated frame.
stat_crc_ok  out  1  residue matched.
stat_runt  out  1  frame shorter than MIN_FRAME.
stat_abort  out  1  frame terminated by a new sop before eop.
stat_len  out  LEN_W  payload byte count (total minus 4), clipped at 0.

Behaviour:
- Reset: synchronous, active-high, sampled at the clk edge.
  - All outputs go to 0.
  - CRC register goes to 32'hFFFFFFFF, byte count to 0, delay-line occupancy to 0, FSM to IDLE.
  - Reset overrides all inputs in the same cycle. A frame in progress at reset is discarded with no status pulse.
- CRC arithmetic:
  - Reflected polynomial 0xEDB88320, byte step crc = (crc>>8) ^ T[crc[7:0]^byte].
  - Each frame starts from 0xFFFFFFFF, seeded on its sop byte.
  - After the final byte (the FCS) the good-frame register value is the residue 32'hDEBB20E3.
  - stat_crc_ok = (next_crc == residue), evaluated on the eop beat.
- FSM states: IDLE, FRAME.
  - IDLE with in_valid & in_sop & ~in_eop: go to FRAME, load CRC with step(0xFFFFFFFF, byte), set count=1, push byte into the delay line.
  - IDLE with in_valid & in_sop & in_eop: single-byte frame. Next cycle stat_valid=1, stat_runt=1, stat_crc_ok=0, stat_len=0. Stay in IDLE.
  - IDLE with in_valid & ~in_sop: byte dropped, no outputs.
  - FRAME with in_valid & ~in_sop: step CRC, increment count (saturating), push byte.
    - If the delay line already held 4 bytes, the oldest byte appears on out_data with out_valid=1 in the next cycle.
  - FRAME with in_valid & in_eop:
    - If the delay line was full, the popped byte is emitted with out_last=1.
    - Next cycle: stat_valid=1, stat_len=count+1-4 (0 if runt), stat_runt=(count+1<MIN_FRAME), stat_crc_ok=residue match & ~runt.
    - Go to IDLE; clear the delay line.
  - FRAME with in_valid & in_sop (abort): emit status for the old frame next cycle with stat_abort=1, stat_crc_ok=0, stat_len=payload already forwarded.
    - The buffered bytes are discarded, and no out_last is emitted for the aborted frame.
    - The new byte starts a fresh frame under the IDLE sop rules, in the same cycle.
- Latency: a payload byte is output registered, 1 cycle after the beat that pushes it out, i.e. at byte index i+4. The status pulse comes 1 cycle after the eop beat.
- in_valid low: no state change, no output. Gaps within a frame are allowed.
- Back-to-back frames (sop on the cycle after eop) are legal at full rate. Status and the out_last byte of frame k may overlap the first cycles of frame k+1.
- Runt frames (count below MIN_FRAME) never assert out_last. A frame of 5 to 4+N bytes emits exactly total-4 payload bytes.
- out_valid, out_last and stat_* are registered. stat_* is valid only while stat_valid=1.

Decomposition:
- Package crc32_pkg holds:
  - constants CRC32_INIT=32'hFFFFFFFF, CRC32_POLY_REFL=32'hEDB88320, CRC32_RESIDUE=32'hDEBB20E3;
  - function crc32_byte_step(crc, byte), table-based, shared with the generator;
  - enum typedef for the FSM states.
- Sub-module crc32_fcs_delay: a 4-entry byte shift register with occupancy count. It provides push, flush and a pop-valid output.

Test Plan:
- Good frame: bytes 31 32 33 34 35 36 37 38 39 26 39 F4 CB (sop on the first, eop on the last) -> out bytes 31..39 with out_last on 39; stat_valid, crc_ok=1, len=9, runt=0, abort=0.
- Corrupt frame: same frame with 35 changed to 34 -> 9 payload bytes forwarded; crc_ok=0, len=9.
- Runt: 3 bytes AA BB CC with eop on CC -> no out_valid; stat runt=1, crc_ok=0, len=0. Single-byte sop+eop gives the same result.
- Abort: 7 bytes, then a new sop without eop, followed by the good frame -> first status abort=1, len=3; then the good frame's status crc_ok=1, len=9.
- Back-to-back good frames with 0-cycle gap, plus random in_valid gaps -> two statuses with crc_ok=1, payload intact, out_last correct.
- rst asserted mid-frame for 1 cycle, then the good frame -> no status for the partial frame; the following frame gives crc_ok=1, len=9.
